score_scheduler: RTL and testbench

Arbitrates score events from up to four game requesters (pellet, power pellet, ghost, fruit) and applies each event's point value to a 4-digit BCD score register. Each add is performed digit-serially, one digit per clock, and is committed atomically. The block sits between the game-logic event sources and the seven-segment display driver. It replaces direct binary-point feeding of the display with a BCD accumulator that saturates at 9999.

---
 rtl/score_scheduler_if.sv | 34 +++
 rtl/score_scheduler.sv | 155 +++++++++++++++
 tb/tb_score_scheduler.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/score_scheduler_if.sv
// Score scheduler bus: event requests and clear from the game logic, grants and
// the committed BCD score back to the requesters and the display driver.
//   clear    : synchronous score clear (master -> slave)
//   req[3:0] : level request per requester (master -> slave)
//   ack[3:0] : one-hot, one-cycle grant pulse (slave -> master)
//   BCD      : committed score {thousands, hundreds, tens, ones} (slave -> master)
//   busy     : an add is in flight (slave -> master)
//   overflow : sticky saturation flag (slave -> master)
interface score_scheduler_if;
  logic        clear;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [15:0] BCD;
  logic        busy;
  logic        overflow;

  modport master (
    output clear,
    output req,
    input  ack,
    input  BCD,
    input  busy,
    input  overflow
  );

  modport slave (
    input  clear,
    input  req,
    output ack,
    output BCD,
    output busy,
    output overflow
  );
endinterface

// File: rtl/score_scheduler.sv
// Round-robin score event arbiter with a digit-serial 4-digit BCD accumulator.
// Each granted event adds its requester's BCD point value one digit per clock;
// the result is committed in a single edge and saturates at 9999.
//   display_clk : sole clock, rising edge
//   RST         : asynchronous active-high reset
//   bus         : score_scheduler_if slave (clear, req in; ack, BCD, busy, overflow out)
module score_scheduler #(
  parameter logic [15:0] PTS0 = 16'h0010,
  parameter logic [15:0] PTS1 = 16'h0050,
  parameter logic [15:0] PTS2 = 16'h0200,
  parameter logic [15:0] PTS3 = 16'h0100
) (
  input  logic              display_clk,
  input  logic              RST,
  score_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAdd, StCommit} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  d_q, d_d;
  logic        carry_q, carry_d;
  logic [15:0] work_q, work_d;
  logic [15:0] addend_q, addend_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  ack_q, ack_d;

  logic        gnt_valid;
  logic [1:0]  gnt_idx;
  logic [1:0]  probe;
  logic [15:0] gnt_pts;
  logic [4:0]  digit_sum;
  logic [4:0]  digit_adj;

  // Round-robin search: walk offsets high to low so the lowest offset from rr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = rr_q;
    probe     = rr_q;
    for (int i = 3; i >= 0; i--) begin
      probe = rr_q + 2'(i);
      if (bus.req[probe]) begin
        gnt_valid = 1'b1;
        gnt_idx   = probe;
      end
    end
  end

  always_comb begin
    unique case (gnt_idx)
      2'd0:    gnt_pts = PTS0;
      2'd1:    gnt_pts = PTS1;
      2'd2:    gnt_pts = PTS2;
      default: gnt_pts = PTS3;
    endcase
  end

  // Current digit: 5-bit sum so a carry-in on 9+9 cannot wrap.
  always_comb begin
    digit_sum = {1'b0, work_q[{d_q, 2'b00} +: 4]} + {1'b0, addend_q[{d_q, 2'b00} +: 4]}
                + {4'b0000, carry_q};
    digit_adj = digit_sum - 5'd10;
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    d_d      = d_q;
    carry_d  = carry_q;
    work_d   = work_q;
    addend_d = addend_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    ack_d    = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          ack_d    = 4'b0001 << gnt_idx;
          addend_d = gnt_pts;
          work_d   = bcd_q;
          d_d      = 2'd0;
          carry_d  = 1'b0;
          rr_d     = gnt_idx + 2'd1;
          state_d  = StAdd;
        end
      end
      StAdd: begin
        if (digit_sum > 5'd9) begin
          work_d[{d_q, 2'b00} +: 4] = digit_adj[3:0];
          carry_d = 1'b1;
        end else begin
          work_d[{d_q, 2'b00} +: 4] = digit_sum[3:0];
          carry_d = 1'b0;
        end
        d_d = d_q + 2'd1;
        if (d_q == 2'd3) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        // Carry out of the thousands digit means the true sum exceeded 9999.
        if (carry_q) begin
          bcd_d = 16'h9999;
          ovf_d = 1'b1;
        end else begin
          bcd_d = work_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear wins over everything, discards any in-flight add and keeps rr.
    if (bus.clear) begin
      bcd_d   = 16'h0000;
      ovf_d   = 1'b0;
      ack_d   = 4'b0000;
      rr_d    = rr_q;
      state_d = StIdle;
    end
  end

  always_ff @(posedge display_clk or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      rr_q     <= 2'd0;
      d_q      <= 2'd0;
      carry_q  <= 1'b0;
      work_q   <= 16'h0000;
      addend_q <= 16'h0000;
      bcd_q    <= 16'h0000;
      ovf_q    <= 1'b0;
      ack_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      d_q      <= d_d;
      carry_q  <= carry_d;
      work_q   <= work_d;
      addend_q <= addend_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.BCD      = bcd_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_score_scheduler.sv
// Self-checking bench for score_scheduler: table vectors, directed corner
// sequences and randomized events against a decimal-arithmetic score model.
module tb_score_scheduler;

  logic clk;
  logic rst;

  score_scheduler_if bus_if ();

  score_scheduler #(
    .PTS0(16'h0010),
    .PTS1(16'h0050),
    .PTS2(16'h0200),
    .PTS3(16'h0100)
  ) dut (
    .display_clk(clk),
    .RST(rst),
    .bus(bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain decimal score, point values in decimal.
  int          m_score;
  int          m_rr;
  logic        m_ovf;
  logic [15:0] prev_bcd;
  int          pts_dec [4] = '{10, 50, 200, 100};

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  exp_ack;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_score  = 0;
    m_rr     = 0;
    m_ovf    = 1'b0;
    prev_bcd = 16'h0000;
  endtask

  task automatic model_event(input logic [3:0] r, output logic [3:0] e_ack,
                             output logic [15:0] e_bcd, output logic e_ovf);
    int g;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && r[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    end
    e_ack   = 4'b0001 << g;
    m_score = m_score + pts_dec[g];
    if (m_score > 9999) begin
      m_score = 9999;
      m_ovf   = 1'b1;
    end
    m_rr  = (g + 1) % 4;
    e_bcd = to_bcd(m_score);
    e_ovf = m_ovf;
  endtask

  task automatic do_reset();
    bus_if.req   = 4'b0000;
    bus_if.clear = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // One event from IDLE: req sampled at E0, BCD must stay put until E5.
  task automatic run_event(input logic [3:0] r, input logic [3:0] e_ack,
                           input logic [15:0] e_bcd, input logic e_ovf, input string tag);
    bus_if.req = r;
    tick();
    check({tag, " ack"}, 32'(bus_if.ack), 32'(e_ack));
    check({tag, " busy_e0"}, 32'(bus_if.busy), 32'd1);
    bus_if.req = 4'b0000;
    tick();
    check({tag, " ack_pulse"}, 32'(bus_if.ack), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check({tag, " no_partial"}, 32'(bus_if.BCD), 32'(prev_bcd));
      check({tag, " busy_mid"}, 32'(bus_if.busy), 32'd1);
    end
    tick();
    check({tag, " bcd"}, 32'(bus_if.BCD), 32'(e_bcd));
    check({tag, " ovf"}, 32'(bus_if.overflow), 32'(e_ovf));
    check({tag, " busy_end"}, 32'(bus_if.busy), 32'd0);
    prev_bcd = e_bcd;
  endtask

  task automatic model_run(input logic [3:0] r, input string tag);
    logic [3:0]  ea;
    logic [15:0] eb;
    logic        eo;
    model_event(r, ea, eb, eo);
    run_event(r, ea, eb, eo, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  ea;
    logic [15:0] eb;
    logic        eo;

    vecs[0] = '{4'b0001, 4'b0001, 16'h0010, 1'b0};
    vecs[1] = '{4'b0001, 4'b0001, 16'h0020, 1'b0};
    vecs[2] = '{4'b1001, 4'b1000, 16'h0120, 1'b0};
    vecs[3] = '{4'b1001, 4'b0001, 16'h0130, 1'b0};
    vecs[4] = '{4'b0110, 4'b0010, 16'h0180, 1'b0};
    vecs[5] = '{4'b0110, 4'b0100, 16'h0380, 1'b0};
    vecs[6] = '{4'b0010, 4'b0010, 16'h0430, 1'b0};
    vecs[7] = '{4'b1111, 4'b0100, 16'h0630, 1'b0};
    vecs[8] = '{4'b1111, 4'b1000, 16'h0730, 1'b0};

    rst = 1'b1;
    bus_if.req   = 4'b0000;
    bus_if.clear = 1'b0;
    #12;
    check("reset bcd", 32'(bus_if.BCD), 32'h0);
    check("reset ack", 32'(bus_if.ack), 32'h0);
    check("reset busy", 32'(bus_if.busy), 32'h0);
    check("reset ovf", 32'(bus_if.overflow), 32'h0);
    do_reset();

    // Table vectors: round-robin order and accumulated score from reset.
    for (int i = 0; i < 9; i++) begin
      run_event(vecs[i].req, vecs[i].exp_ack, vecs[i].exp_bcd, vecs[i].exp_ovf,
                $sformatf("vec%0d", i));
    end

    // Carry chain: 0990 + 10 -> 1000.
    do_reset();
    for (int i = 0; i < 99; i++) model_run(4'b0001, "preload");
    check("preload 0990", 32'(bus_if.BCD), 32'h0990);
    run_event(4'b0001, 4'b0001, 16'h1000, 1'b0, "carry_chain");
    m_score = 1000;
    m_rr    = 1;

    // Continuous 1111 from reset: grants 0,1,2,3 at 6-cycle intervals.
    do_reset();
    bus_if.req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      tick();
      check($sformatf("rr_grant%0d", g), 32'(bus_if.ack), 32'(4'b0001 << g));
      for (int c = 0; c < 5; c++) begin
        tick();
        check("rr_ack_gap", 32'(bus_if.ack), 32'd0);
      end
    end
    bus_if.req = 4'b0000;
    check("rr_bcd_0360", 32'(bus_if.BCD), 32'h0360);

    // Saturation at 9999.
    do_reset();
    for (int i = 0; i < 49; i++) model_run(4'b0100, "sat_pre");
    for (int i = 0; i < 3; i++) model_run(4'b0010, "sat_pre");
    check("sat 9950", 32'(bus_if.BCD), 32'h9950);
    model_run(4'b0010, "saturate");
    check("sat ovf", 32'(bus_if.overflow), 32'd1);
    model_run(4'b0100, "sat_hold");

    // Clear while digit 2 is being added: event discarded, rr kept.
    model_event(4'b0100, ea, eb, eo);
    bus_if.req = 4'b0100;
    tick();
    check("clr ack", 32'(bus_if.ack), 32'(ea));
    bus_if.req = 4'b0000;
    tick();
    tick();
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    check("clr bcd", 32'(bus_if.BCD), 32'h0);
    check("clr ovf", 32'(bus_if.overflow), 32'd0);
    check("clr idle", 32'(bus_if.busy), 32'd0);
    m_score  = 0;
    m_ovf    = 1'b0;
    prev_bcd = 16'h0000;
    model_run(4'b0001, "after_clear");
    check("after_clear 0010", 32'(bus_if.BCD), 32'h0010);

    // Clear with req in IDLE: no grant.
    bus_if.req   = 4'b0001;
    bus_if.clear = 1'b1;
    tick();
    check("clr_vs_req ack", 32'(bus_if.ack), 32'd0);
    check("clr_vs_req busy", 32'(bus_if.busy), 32'd0);
    bus_if.req   = 4'b0000;
    bus_if.clear = 1'b0;
    m_score  = 0;
    prev_bcd = 16'h0000;

    // Async reset between E2 and E3, then rr must restart at 0.
    model_run(4'b0100, "pre_rst");
    bus_if.req = 4'b0100;
    tick();
    bus_if.req = 4'b0000;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst bcd", 32'(bus_if.BCD), 32'h0);
    check("rst ack", 32'(bus_if.ack), 32'h0);
    check("rst busy", 32'(bus_if.busy), 32'h0);
    tick();
    rst = 1'b0;
    model_reset();
    model_run(4'b1111, "post_rst");

    // Randomized events against the model.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      model_run(4'($urandom_range(1, 15)), $sformatf("rand%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) tick();
        check("rand idle ack", 32'(bus_if.ack), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
